// File: rtl/sample_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_seq_pkg : shared widths, defaults and state codes            |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package sample_seq_pkg;

  localparam int TAP_IDX_W = 4;
  localparam int COUNT_W   = 5;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_NUM_TAPS    = 12;
  localparam int DEF_NUM_SAMPLES = 20;
  localparam int DEF_GAP         = 1;
  localparam int DEF_TIMEOUT     = 64;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_LOAD      = 3'd1;
  localparam seq_state_t ST_FRAME     = 3'd2;
  localparam seq_state_t ST_STROBE    = 3'd3;
  localparam seq_state_t ST_GAP       = 3'd4;
  localparam seq_state_t ST_WAIT_DONE = 3'd5;
  localparam seq_state_t ST_DONE      = 3'd6;

endpackage
`default_nettype wire

// File: rtl/srdy_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | srdy_edge_det : rising-edge detect against a registered copy        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module srdy_edge_det (
  input  logic clk,
  input  logic GlobalReset_n,
  input  logic sig,
  output logic rise
);

  logic r_sig_q;

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= sig;
    end
  end

  // A level held over several cycles yields a single event.
  assign rise = sig & ~r_sig_q;

endmodule
`default_nettype wire

// File: rtl/sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_sequencer : feeds one sample per frame to the tap-serial MAC |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module sample_sequencer
  import sample_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int GAP         = DEF_GAP,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 GlobalReset_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [DATA_W-1:0]    sample_out,
  output logic                 global_srdyi,
  output logic                 srdyi,
  output logic [TAP_IDX_W-1:0] tap_idx,
  input  logic                 srdyo,
  output logic [COUNT_W-1:0]   count_global,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int CNT_MAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     C_GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0]     C_TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [TAP_IDX_W-1:0] C_TAP_LAST  = TAP_IDX_W'(NUM_TAPS - 1);
  localparam logic [COUNT_W-1:0]   C_RUN_LEN   = COUNT_W'(NUM_SAMPLES);

  seq_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [TAP_IDX_W-1:0]  r_tap;
  logic [COUNT_W-1:0]    r_count;
  logic [DATA_W-1:0]     r_sample;
  logic                  r_error;
  logic                  r_armed;

  logic                  w_srdyo_evt;
  logic [COUNT_W-1:0]    w_count_next;

  srdy_edge_det u_srdyo_edge (
    .clk           (clk),
    .GlobalReset_n (GlobalReset_n),
    .sig           (srdyo),
    .rise          (w_srdyo_evt)
  );

  assign w_count_next = r_count + COUNT_W'(1);

  // r_armed masks a start that coincides with the first edge after reset release.
  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tap    <= '0;
      r_count  <= '0;
      r_sample <= '0;
      r_error  <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start && r_armed) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (din_valid) begin
            r_sample <= din;
            r_state  <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          r_tap   <= '0;
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          r_cnt   <= '0;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (r_cnt == C_GAP_LAST) begin
            r_cnt <= '0;
            if (r_tap == C_TAP_LAST) begin
              r_state <= ST_WAIT_DONE;
            end else begin
              r_tap   <= r_tap + TAP_IDX_W'(1);
              r_state <= ST_STROBE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (w_srdyo_evt) begin
            r_cnt   <= '0;
            r_count <= w_count_next;
            r_state <= (w_count_next == C_RUN_LEN) ? ST_DONE : ST_LOAD;
          end else if (r_cnt == C_TMO_LAST) begin
            r_cnt   <= '0;
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // Early completion is flagged but never alters the sequence; it wins over a start clear.
      if (w_srdyo_evt && (r_state != ST_WAIT_DONE)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign din_ready    = (r_state == ST_LOAD);
  assign global_srdyi = (r_state == ST_FRAME);
  assign srdyi        = (r_state == ST_STROBE);
  assign done         = (r_state == ST_DONE);
  assign busy         = (r_state != ST_IDLE);
  assign sample_out   = r_sample;
  assign tap_idx      = r_tap;
  assign count_global = r_count;
  assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sample_sequencer : randomized bench with a transaction-level model|
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_sample_sequencer;

  localparam int DATA_W      = 16;
  localparam int NUM_TAPS    = 12;
  localparam int NUM_SAMPLES = 20;
  localparam int GAP         = 1;
  localparam int TIMEOUT     = 64;

  localparam int ST_NEXT  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_TMO   = 2;
  localparam int ST_ABORT = 3;

  logic              clk = 1'b0;
  logic              GlobalReset_n;
  logic              start;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] sample_out;
  logic              global_srdyi;
  logic              srdyi;
  logic [3:0]        tap_idx;
  logic              srdyo;
  logic [4:0]        count_global;
  logic              busy;
  logic              done;
  logic              error;

  int n_checks = 0;
  int n_errors = 0;
  int n_gs = 0;
  int n_srdyi = 0;
  int n_done = 0;
  int hold = 0;
  int exp_count = 0;
  bit exp_error = 1'b0;

  sample_sequencer #(
    .DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS), .NUM_SAMPLES(NUM_SAMPLES),
    .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .GlobalReset_n(GlobalReset_n), .start(start),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sample_out(sample_out), .global_srdyi(global_srdyi), .srdyi(srdyi),
    .tap_idx(tap_idx), .srdyo(srdyo), .count_global(count_global),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set before this are sampled at the edge; outputs are then observed.
  task automatic tick();
    @(posedge clk);
    #1;
    if (hold > 0) begin
      hold--;
      if (hold == 0) srdyo = 1'b0;
    end
    if (global_srdyi) n_gs++;
    if (srdyi) n_srdyi++;
    if (done) n_done++;
    check("strobe_excl", 32'(global_srdyi & srdyi), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, 32'(din_ready), 32'd0);
    check({tag, "_sample"}, 32'(sample_out), 32'd0);
    check({tag, "_gs"}, 32'(global_srdyi), 32'd0);
    check({tag, "_srdyi"}, 32'(srdyi), 32'd0);
    check({tag, "_tap"}, 32'(tap_idx), 32'd0);
    check({tag, "_count"}, 32'(count_global), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_count = 0;
    exp_error = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(din_ready), 32'd1);
    check("start_count", 32'(count_global), 32'd0);
    check("start_error", 32'(error), 32'd0);
  endtask

  // One sample frame as seen from the sequencer's ports, timed from the accept edge.
  task automatic run_sample(input logic [DATA_W-1:0] data, input int stall, input int delay,
                            input int width, input int early_tap, input int abort_tap,
                            output int status);
    bit got_evt;
    got_evt = 1'b0;
    status = ST_NEXT;
    for (int i = 0; i < stall; i++) begin
      check("ld_ready", 32'(din_ready), 32'd1);
      check("ld_gs", 32'(global_srdyi), 32'd0);
      check("ld_srdyi", 32'(srdyi), 32'd0);
      din = DATA_W'($urandom);
      din_valid = 1'b0;
      start = (i == 1);
      tick();
      start = 1'b0;
    end
    check("ld_ready", 32'(din_ready), 32'd1);
    din = data;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din = DATA_W'($urandom);
    check("frame_gs", 32'(global_srdyi), 32'd1);
    check("frame_srdyi", 32'(srdyi), 32'd0);
    check("frame_ready", 32'(din_ready), 32'd0);
    check("frame_sample", 32'(sample_out), 32'(data));
    tick();
    for (int t = 0; t < NUM_TAPS; t++) begin
      check("strobe", 32'(srdyi), 32'd1);
      check("strobe_gs", 32'(global_srdyi), 32'd0);
      check("strobe_tap", 32'(tap_idx), 32'(t));
      check("strobe_sample", 32'(sample_out), 32'(data));
      check("strobe_error", 32'(error), 32'(exp_error));
      if (t == abort_tap) begin
        #2 GlobalReset_n = 1'b0;
        #1;
        status = ST_ABORT;
        return;
      end
      if (t == early_tap) begin
        srdyo = 1'b1;
        hold = 1;
      end
      tick();
      if (t == early_tap) exp_error = 1'b1;
      for (int g = 0; g < GAP; g++) begin
        check("gap_srdyi", 32'(srdyi), 32'd0);
        check("gap_tap", 32'(tap_idx), 32'(t));
        tick();
      end
    end
    for (int i = 0; i < TIMEOUT; i++) begin
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_srdyi", 32'(srdyi), 32'd0);
      check("wait_ready", 32'(din_ready), 32'd0);
      check("wait_tap", 32'(tap_idx), 32'(NUM_TAPS - 1));
      check("wait_count", 32'(count_global), 32'(exp_count));
      if (i == delay) begin
        srdyo = 1'b1;
        hold = width;
        tick();
        got_evt = 1'b1;
        break;
      end
      tick();
    end
    if (!got_evt) begin
      exp_error = 1'b1;
      status = ST_TMO;
      check("tmo_busy", 32'(busy), 32'd0);
      check("tmo_error", 32'(error), 32'd1);
      check("tmo_count", 32'(count_global), 32'(exp_count));
      return;
    end
    exp_count++;
    check("evt_count", 32'(count_global), 32'(exp_count));
    check("evt_error", 32'(error), 32'(exp_error));
    if (exp_count == NUM_SAMPLES) begin
      status = ST_DONE;
      check("done_pulse", 32'(done), 32'd1);
      tick();
      check("done_width", 32'(done), 32'd0);
      check("done_idle", 32'(busy), 32'd0);
      check("done_count", 32'(count_global), 32'(NUM_SAMPLES));
    end else begin
      check("next_done", 32'(done), 32'd0);
      check("next_ready", 32'(din_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    int base_gs, base_srdyi, base_done;
    GlobalReset_n = 1'b0;
    start = 1'b0;
    din = '0;
    din_valid = 1'b0;
    srdyo = 1'b0;
    tick();
    tick();
    check_zero_outputs("rst");

    // Start arriving together with reset release must be ignored.
    GlobalReset_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_start_busy", 32'(busy), 32'd0);
    check("ign_start_ready", 32'(din_ready), 32'd0);
    tick();

    // Nominal run: din = 1..20, prompt completion.
    base_gs = n_gs;
    base_srdyi = n_srdyi;
    base_done = n_done;
    do_start();
    for (int s = 0; s < NUM_SAMPLES; s++) begin
      run_sample(DATA_W'(s + 1), 0, 0, 1, -1, -1, st);
      check("nom_status", 32'(st), (s == NUM_SAMPLES - 1) ? 32'(ST_DONE) : 32'(ST_NEXT));
    end
    check("nom_n_gs", 32'(n_gs - base_gs), 32'(NUM_SAMPLES));
    check("nom_n_srdyi", 32'(n_srdyi - base_srdyi), 32'(NUM_SAMPLES * NUM_TAPS));
    check("nom_n_done", 32'(n_done - base_done), 32'd1);
    check("nom_error", 32'(error), 32'd0);
    tick();

    // Stall, long srdyo, early srdyo, then timeout.
    do_start();
    run_sample(DATA_W'($urandom), 5, 1, 1, -1, -1, st);
    check("stall_status", 32'(st), 32'(ST_NEXT));
    run_sample(DATA_W'($urandom), 0, 2, 4, -1, -1, st);
    check("long_status", 32'(st), 32'(ST_NEXT));
    run_sample(DATA_W'($urandom), 2, 0, 1, 3, -1, st);
    check("early_status", 32'(st), 32'(ST_NEXT));
    check("early_error", 32'(error), 32'd1);
    run_sample(DATA_W'($urandom), 0, TIMEOUT, 1, -1, -1, st);
    check("tmo_status", 32'(st), 32'(ST_TMO));
    tick();
    check("tmo_hold_count", 32'(count_global), 32'd3);
    check("tmo_hold_error", 32'(error), 32'd1);

    // Reset during tap 7 of sample 5.
    do_start();
    for (int s = 0; s < 4; s++) begin
      run_sample(DATA_W'($urandom), $urandom_range(0, 2), $urandom_range(0, 4), 1, -1, -1, st);
    end
    run_sample(DATA_W'($urandom | 1), 0, 0, 1, -1, 7, st);
    check("abort_status", 32'(st), 32'(ST_ABORT));
    check_zero_outputs("abort");
    hold = 0;
    srdyo = 1'b0;
    tick();
    tick();
    GlobalReset_n = 1'b1;
    tick();
    check_zero_outputs("post_rst");

    // Fully randomized run to completion.
    base_done = n_done;
    do_start();
    for (int s = 0; s < NUM_SAMPLES; s++) begin
      int et;
      et = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NUM_TAPS - 2)) : -1;
      run_sample(DATA_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 5),
                 $urandom_range(1, 3), et, -1, st);
      check("rnd_status", 32'(st), (s == NUM_SAMPLES - 1) ? 32'(ST_DONE) : 32'(ST_NEXT));
    end
    check("rnd_n_done", 32'(n_done - base_done), 32'd1);
    check("rnd_error", 32'(error), 32'(exp_error));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
